// File: rtl/coeff_unpacker.sv
// coeff_unpacker: unpacks an LSB-first 32-bit word stream into COEFF_W-bit coefficients,
// either raw or centred-binomial decoded modulo Q.
module coeff_unpacker #(
    parameter int COEFF_W = 2,
    parameter int N_COEFF = 256,
    parameter int Q       = 3329
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cbd_mode,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_coeff,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);
    localparam int N_WORDS = (N_COEFF * COEFF_W + 31) / 32;
    localparam int ETA     = COEFF_W / 2;
    localparam int CW      = $clog2(N_COEFF + 1);
    localparam int WW      = $clog2(N_WORDS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_next;
    logic [63:0]     buffer, buffer_next, shifted;
    logic [6:0]      fill, fill_next, fill_shifted;
    logic [CW-1:0]   coeff_cnt, coeff_cnt_next;
    logic [WW-1:0]   word_cnt, word_cnt_next;
    logic            mode, mode_next;
    logic            take_in, take_out;
    logic [3:0]      a, b;

    assign take_in  = in_valid && in_ready;
    assign take_out = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            buffer    <= '0;
            fill      <= '0;
            coeff_cnt <= '0;
            word_cnt  <= '0;
            mode      <= 1'b0;
        end else begin
            state     <= state_next;
            buffer    <= buffer_next;
            fill      <= fill_next;
            coeff_cnt <= coeff_cnt_next;
            word_cnt  <= word_cnt_next;
            mode      <= mode_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && take_in)
            state_next = RUN;
        else if (take_out && out_last)
            state_next = IDLE;
    end

    // Buffer above fill is always zero, so IDLE loads reuse the generic append path at fill 0.
    always_comb begin
        shifted        = take_out ? buffer >> COEFF_W : buffer;
        fill_shifted   = take_out ? fill - 7'(COEFF_W) : fill;
        buffer_next    = take_in ? shifted | ({32'b0, in_data} << fill_shifted) : shifted;
        fill_next      = take_in ? fill_shifted + 7'd32 : fill_shifted;
        word_cnt_next  = word_cnt + WW'(take_in);
        coeff_cnt_next = coeff_cnt + CW'(take_out);
        mode_next      = mode;
        if (state == IDLE) begin
            mode_next      = take_in ? cbd_mode : mode;
            word_cnt_next  = take_in ? WW'(1) : '0;
            coeff_cnt_next = '0;
        end else if (take_out && out_last) begin
            buffer_next = '0;
            fill_next   = '0;
        end
    end

    always_comb begin
        in_ready  = state == IDLE || (fill <= 7'd32 && word_cnt < WW'(N_WORDS));
        out_valid = state == RUN && fill >= 7'(COEFF_W);
        out_last  = out_valid && coeff_cnt == CW'(N_COEFF - 1);
        a = '0;
        b = '0;
        for (int i = 0; i < ETA; i++) begin
            a = a + {3'b0, buffer[i]};
            b = b + {3'b0, buffer[ETA + i]};
        end
        out_coeff = !mode ? 12'(buffer[COEFF_W-1:0]) :
                    a >= b ? 12'(a - b) : 12'(Q) - 12'(b - a);
    end
endmodule

// File: tb/tb_coeff_unpacker.sv
// tb_coeff_unpacker: directed and randomised-handshake checks of coeff_unpacker
// (COEFF_W=2 full polynomials, COEFF_W=12 word straddle).
module tb_coeff_unpacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cbd2, iv2, ir2, ov2, or2, ol2;
    logic [31:0] id2;
    logic [11:0] oc2;
    logic        cbd12, iv12, ir12, ov12, or12, ol12;
    logic [31:0] id12;
    logic [11:0] oc12;

    coeff_unpacker #(.COEFF_W(2), .N_COEFF(256), .Q(3329)) u2 (
        .clk(clk), .rst_n(rst_n), .cbd_mode(cbd2), .in_data(id2), .in_valid(iv2),
        .in_ready(ir2), .out_coeff(oc2), .out_valid(ov2), .out_ready(or2), .out_last(ol2)
    );

    coeff_unpacker #(.COEFF_W(12), .N_COEFF(3), .Q(3329)) u12 (
        .clk(clk), .rst_n(rst_n), .cbd_mode(cbd12), .in_data(id12), .in_valid(iv12),
        .in_ready(ir12), .out_coeff(oc12), .out_valid(ov12), .out_ready(or12), .out_last(ol12)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] w2 [16];
    logic [11:0] g2 [256];
    logic        gl2 [256];
    int          gc [256];
    int          got_n, ext_n, stab_n, cyc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the word array and bit position.
    function automatic logic [11:0] model2(input int k, input bit m);
        int x, y;
        x = int'(w2[(2*k)/32][(2*k)%32]);
        y = int'(w2[(2*k+1)/32][(2*k+1)%32]);
        if (!m) return 12'(2*y + x);
        return x >= y ? 12'(x - y) : 12'(3329 - (y - x));
    endfunction

    task automatic run2(input bit m, input bit rnd, input int stop);
        int wi = 0;
        bit stalled = 0;
        logic [11:0] prev = '0;
        got_n = 0; ext_n = 0; stab_n = 0; cyc = 0;
        while (got_n < stop && cyc < 20000) begin
            @(negedge clk);
            if (stalled && oc2 !== prev) stab_n++;
            cbd2 = wi == 0 ? m : !m;
            iv2 = !rnd || $urandom_range(0, 1) == 1;
            id2 = (iv2 && wi < 16) ? w2[wi] : $urandom;
            or2 = !rnd || $urandom_range(0, 2) != 0;
            if (iv2 && ir2) begin
                if (wi < 16) wi++;
                else ext_n++;
            end
            if (ov2 && or2) begin
                g2[got_n] = oc2;
                gl2[got_n] = ol2;
                gc[got_n] = cyc;
                got_n++;
            end
            stalled = ov2 && !or2;
            prev = oc2;
            cyc++;
        end
    endtask

    task automatic check_poly(input string tag, input bit m);
        int mism = 0;
        int lasts = 0;
        chk({tag, " count"}, got_n, 256);
        for (int k = 0; k < got_n; k++) begin
            if (g2[k] !== model2(k, m)) mism++;
            if (gl2[k]) lasts++;
        end
        chk({tag, " data_mismatches"}, mism, 0);
        chk({tag, " last_count"}, lasts, 1);
        chk({tag, " last_on_256th"}, 32'(gl2[255]), 1);
        chk({tag, " extra_word_accepted"}, ext_n, 0);
        chk({tag, " stall_instability"}, stab_n, 0);
        @(negedge clk);
        chk({tag, " idle_in_ready"}, 32'(ir2), 1);
        chk({tag, " idle_out_valid"}, 32'(ov2), 0);
        iv2 = 1'b0;
    endtask

    initial begin
        cbd2 = 0; iv2 = 0; id2 = 0; or2 = 0;
        cbd12 = 0; iv12 = 0; id12 = 0; or12 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(ir2), 1);
        chk("rst out_valid", 32'(ov2), 0);
        chk("rst out_coeff", 32'(oc2), 0);
        chk("rst out_last", 32'(ol2), 0);
        chk("rst12 in_ready", 32'(ir12), 1);
        chk("rst12 out_valid", 32'(ov12), 0);
        rst_n = 1'b1;

        foreach (w2[i]) w2[i] = '0;
        w2[0] = 32'h0000_00E4;
        run2(1'b0, 1'b0, 256);
        chk("raw c0", 32'(g2[0]), 0);
        chk("raw c1", 32'(g2[1]), 1);
        chk("raw c2", 32'(g2[2]), 2);
        chk("raw c3", 32'(g2[3]), 3);
        chk("raw consecutive", gc[3] - gc[0], 3);
        check_poly("raw", 1'b0);

        run2(1'b1, 1'b0, 256);
        chk("cbd c0", 32'(g2[0]), 0);
        chk("cbd c1", 32'(g2[1]), 1);
        chk("cbd c2", 32'(g2[2]), 3328);
        chk("cbd c3", 32'(g2[3]), 0);
        check_poly("cbd", 1'b1);

        @(negedge clk);
        iv12 = 1; id12 = 32'hABCD_E123; or12 = 1;
        @(negedge clk);
        chk("w12 c0 valid", 32'(ov12), 1);
        chk("w12 c0", 32'(oc12), 32'h123);
        chk("w12 c0 last", 32'(ol12), 0);
        chk("w12 second word ready", 32'(ir12), 1);
        id12 = 32'h0000_0005;
        @(negedge clk);
        chk("w12 c1", 32'(oc12), 32'hCDE);
        chk("w12 c1 last", 32'(ol12), 0);
        chk("w12 full no ready", 32'(ir12), 0);
        id12 = 32'hFFFF_FFFF; or12 = 0;
        @(negedge clk);
        chk("w12 stall valid", 32'(ov12), 1);
        chk("w12 stall c1", 32'(oc12), 32'hCDE);
        or12 = 1;
        @(negedge clk);
        chk("w12 c2", 32'(oc12), 32'h5AB);
        chk("w12 c2 last", 32'(ol12), 1);
        @(negedge clk);
        chk("w12 idle valid", 32'(ov12), 0);
        chk("w12 idle ready", 32'(ir12), 1);
        iv12 = 0;

        for (int p = 0; p < 10; p++) begin
            foreach (w2[i]) w2[i] = $urandom;
            run2(p[0], 1'b1, 256);
            check_poly($sformatf("rnd%0d", p), p[0]);
        end

        foreach (w2[i]) w2[i] = $urandom;
        run2(1'b1, 1'b1, 50);
        chk("mid got 50", got_n, 50);
        rst_n = 1'b0; iv2 = 0; or2 = 1;
        @(negedge clk);
        chk("midrst out_valid", 32'(ov2), 0);
        chk("midrst in_ready", 32'(ir2), 1);
        chk("midrst out_coeff", 32'(oc2), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst no stale", 32'(ov2), 0);
        foreach (w2[i]) w2[i] = $urandom;
        run2(1'b0, 1'b1, 256);
        check_poly("post_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
